// File: rtl/ai_move_driver.sv
// Tic-tac-toe computer opponent: scans the board, picks a cell, drives a one-hot switch word and a confirm pulse.
// Optional macro AI_RANDOM_EN: LFSR-randomised choice for the non-tactical (centre/corner/side) moves.
module ai_move_driver #(
  parameter int unsigned THINK_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT  = 1024,
  parameter bit          AI_TURN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_flag,
  input  logic        enable,
  input  logic [17:0] grid_state,
  input  logic        turn,
  input  logic [1:0]  game_result,
  output logic [8:0]  sw_out,
  output logic        btn_out,
  output logic        busy,
  output logic [3:0]  move_idx
);

  localparam int unsigned THINK_W = $clog2(THINK_CYCLES + 1);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int unsigned ACK_W   = $clog2(ACK_TIMEOUT);
  localparam int unsigned CNT_W0  = (THINK_W > ACK_W) ? THINK_W : ACK_W;
  localparam int unsigned CNT_W1  = (CNT_W0 > HOLD_W) ? CNT_W0 : HOLD_W;
  localparam int unsigned CNT_W   = (CNT_W1 > 0) ? CNT_W1 : 1;

  localparam logic [1:0] OWN = AI_TURN ? 2'b10 : 2'b01;
  localparam logic [1:0] OPP = AI_TURN ? 2'b01 : 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_THINK, S_SCAN, S_DRIVE, S_PRESS, S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       scan_q, scan_d;
  logic [3:0]       best_rank_q, best_rank_d;
  logic [3:0]       best_cell_q, best_cell_d;
  logic [8:0]       sw_q, sw_d;
  logic             btn_q, btn_d;
  logic             busy_q, busy_d;
  logic [3:0]       move_q, move_d;

  logic       trig_c;
  logic       cand_empty_c;
  logic       win_c, block_c;
  logic [3:0] pos_rank_c, rank_c, pick_c;
  logic       take_c;

  function automatic logic [1:0] cell_at(input logic [17:0] g, input logic [3:0] i);
    return g[{i, 1'b0} +: 2];
  endfunction

  // Zero-based cell triples of the eight winning lines.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  assign trig_c = enable && (turn == AI_TURN) && (game_result == 2'b00);

`ifdef AI_RANDOM_EN
  logic [8:0] lfsr_q;
  logic [3:0] start_q, start_d;

  always_ff @(posedge clk or posedge reset_flag) begin
    if (reset_flag) begin
      lfsr_q  <= 9'h1A5;
      start_q <= '0;
    end else begin
      lfsr_q  <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      start_q <= start_d;
    end
  end

  assign start_d = (state_q == S_THINK && state_d == S_SCAN) ? 4'(lfsr_q % 9'd9) : start_q;

  // Distance from the random start cell, wrapping 9 -> 1.
  always_comb begin
    pos_rank_c = 4'd3;
    if (scan_q >= start_q) pos_rank_c = 4'd3 + (scan_q - start_q);
    else                   pos_rank_c = 4'd3 + 4'(5'(scan_q) + 5'd9 - 5'(start_q));
  end
`else
  always_comb begin
    pos_rank_c = 4'd5;
    if (scan_q == 4'd4)                                   pos_rank_c = 4'd3;
    else if (scan_q inside {4'd0, 4'd2, 4'd6, 4'd8})     pos_rank_c = 4'd4;
  end
`endif

  // Evaluate the candidate cell against every line passing through it.
  always_comb begin
    cand_empty_c = (cell_at(grid_state, scan_q) == 2'b00) || (cell_at(grid_state, scan_q) == 2'b11);
    win_c   = 1'b0;
    block_c = 1'b0;
    for (int l = 0; l < 8; l++) begin
      logic [11:0] ln;
      logic [3:0]  o1, o2;
      logic        on_line;
      ln      = line_cells(3'(l));
      o1      = '0;
      o2      = '0;
      on_line = 1'b1;
      if (scan_q == ln[11:8])     begin o1 = ln[7:4];  o2 = ln[3:0]; end
      else if (scan_q == ln[7:4]) begin o1 = ln[11:8]; o2 = ln[3:0]; end
      else if (scan_q == ln[3:0]) begin o1 = ln[11:8]; o2 = ln[7:4]; end
      else                        on_line = 1'b0;
      if (on_line && cell_at(grid_state, o1) == OWN && cell_at(grid_state, o2) == OWN) win_c = 1'b1;
      if (on_line && cell_at(grid_state, o1) == OPP && cell_at(grid_state, o2) == OPP) block_c = 1'b1;
    end
    rank_c = win_c ? 4'd1 : (block_c ? 4'd2 : pos_rank_c);
    take_c = cand_empty_c && (rank_c < best_rank_q);
    pick_c = take_c ? (scan_q + 4'd1) : best_cell_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    best_rank_d = best_rank_q;
    best_cell_d = best_cell_q;
    sw_d        = sw_q;
    btn_d       = 1'b0;
    move_d      = move_q;
    case (state_q)
      S_IDLE: begin
        if (trig_c) begin
          state_d = S_THINK;
          cnt_d   = '0;
        end
      end
      S_THINK: begin
        if (!trig_c) begin
          state_d = S_IDLE;
          sw_d    = '0;
          move_d  = '0;
        end else if (cnt_q == CNT_W'(THINK_CYCLES)) begin
          state_d     = S_SCAN;
          scan_d      = '0;
          best_rank_d = 4'hF;
          best_cell_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SCAN: begin
        if (!trig_c) begin
          state_d = S_IDLE;
          sw_d    = '0;
          move_d  = '0;
        end else begin
          if (take_c) begin
            best_rank_d = rank_c;
            best_cell_d = scan_q + 4'd1;
          end
          if (scan_q == 4'd8) begin
            move_d = pick_c;
            cnt_d  = '0;
            if (pick_c == 4'd0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DRIVE;
              sw_d    = 9'(1) << (pick_c - 4'd1);
            end
          end else begin
            scan_d = scan_q + 4'd1;
          end
        end
      end
      S_DRIVE: begin
        if (!trig_c) begin
          state_d = S_IDLE;
          sw_d    = '0;
          move_d  = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_PRESS;
          btn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESS: begin
        if (!trig_c) begin
          state_d = S_IDLE;
          sw_d    = '0;
          move_d  = '0;
        end else begin
          state_d = S_WAIT;
          sw_d    = '0;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (turn != AI_TURN || game_result != 2'b00) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        sw_d    = '0;
        move_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset_flag) begin
    if (reset_flag) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      scan_q      <= '0;
      best_rank_q <= 4'hF;
      best_cell_q <= '0;
      sw_q        <= '0;
      btn_q       <= 1'b0;
      busy_q      <= 1'b0;
      move_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      best_rank_q <= best_rank_d;
      best_cell_q <= best_cell_d;
      sw_q        <= sw_d;
      btn_q       <= btn_d;
      busy_q      <= busy_d;
      move_q      <= move_d;
    end
  end

  assign sw_out   = sw_q;
  assign btn_out  = btn_q;
  assign busy     = busy_q;
  assign move_idx = move_q;

endmodule

// File: tb/tb_ai_move_driver.sv
// Bench for ai_move_driver: timeline-based reference model plus directed and random game scenarios.
module tb_ai_move_driver;

  localparam int unsigned T   = 12;
  localparam int unsigned H   = 4;
  localparam int unsigned ACK = 64;
  localparam int LAT = 1 + T + 9 + H;

  logic        clk = 1'b0;
  logic        reset_flag = 1'b1;
  logic        enable = 1'b0;
  logic [17:0] grid_state = '0;
  logic        turn = 1'b0;
  logic [1:0]  game_result = 2'b00;
  logic [8:0]  sw_out;
  logic        btn_out;
  logic        busy;
  logic [3:0]  move_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int btn_seen = 0;
  logic btn_prev = 1'b0;

  ai_move_driver #(
    .THINK_CYCLES(T), .HOLD_CYCLES(H), .ACK_TIMEOUT(ACK), .AI_TURN(1'b1)
  ) dut (
    .clk(clk), .reset_flag(reset_flag), .enable(enable), .grid_state(grid_state),
    .turn(turn), .game_result(game_result), .sw_out(sw_out), .btn_out(btn_out),
    .busy(busy), .move_idx(move_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules on a row/column view of the board.
  function automatic logic [1:0] at(input logic [17:0] g, input int r, input int c);
    return g[2*(3*r+c) +: 2];
  endfunction

  function automatic bit is_empty(input logic [17:0] g, input int k);
    logic [1:0] v;
    v = g[2*(k-1) +: 2];
    return (v == 2'b00) || (v == 2'b11);
  endfunction

  function automatic bit completes(input logic [17:0] g, input int k, input logic [1:0] who);
    int r, c, n;
    r = (k - 1) / 3;
    c = (k - 1) % 3;
    n = 0;
    for (int i = 0; i < 3; i++) if (i != c && at(g, r, i) == who) n++;
    if (n == 2) return 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) if (i != r && at(g, i, c) == who) n++;
    if (n == 2) return 1'b1;
    if (r == c) begin
      n = 0;
      for (int i = 0; i < 3; i++) if (i != r && at(g, i, i) == who) n++;
      if (n == 2) return 1'b1;
    end
    if (r + c == 2) begin
      n = 0;
      for (int i = 0; i < 3; i++) if (i != r && at(g, i, 2 - i) == who) n++;
      if (n == 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int pick(input logic [17:0] g);
    int corners [4];
    int sides [4];
    corners = '{1, 3, 7, 9};
    sides   = '{2, 4, 6, 8};
    for (int k = 1; k <= 9; k++) if (is_empty(g, k) && completes(g, k, 2'b10)) return k;
    for (int k = 1; k <= 9; k++) if (is_empty(g, k) && completes(g, k, 2'b01)) return k;
    if (is_empty(g, 5)) return 5;
    foreach (corners[i]) if (is_empty(g, corners[i])) return corners[i];
    foreach (sides[i]) if (is_empty(g, sides[i])) return sides[i];
    return 0;
  endfunction

  function automatic logic [17:0] board(input logic [8:0] xs, input logic [8:0] os);
    logic [17:0] g;
    g = '0;
    for (int k = 0; k < 9; k++) begin
      if (xs[k])      g[2*k +: 2] = 2'b01;
      else if (os[k]) g[2*k +: 2] = 2'b10;
    end
    return g;
  endfunction

  // Model: 0 idle, 1 move in progress (age = edges since trigger), 2 waiting for the turn flip.
  int         m_mode = 0;
  int         m_age = 0;
  int         m_w = 0;
  logic [8:0] m_sw = '0;
  logic       m_btn = 1'b0;
  logic [3:0] m_mv = '0;

  always @(posedge clk or posedge reset_flag) begin
    if (reset_flag) begin
      m_mode <= 0; m_age <= 0; m_w <= 0; m_sw <= '0; m_btn <= 1'b0; m_mv <= '0;
    end else begin
      int mode_n, age_n, w_n;
      logic [8:0] sw_n;
      logic btn_n;
      logic [3:0] mv_n;
      bit trig;
      trig = enable && turn && (game_result == 2'b00);
      mode_n = m_mode; age_n = m_age; w_n = m_w; sw_n = m_sw; btn_n = 1'b0; mv_n = m_mv;
      if (m_mode == 0) begin
        if (trig) begin mode_n = 1; age_n = 0; end
      end else if (m_mode == 1) begin
        if (!trig) begin
          mode_n = 0; sw_n = '0; mv_n = '0;
        end else begin
          age_n = m_age + 1;
          if (age_n == T + 10) begin
            mv_n = 4'(pick(grid_state));
            if (mv_n == 0) mode_n = 0;
            else sw_n = 9'(1) << (mv_n - 4'd1);
          end else if (age_n == LAT) begin
            btn_n = 1'b1;
          end else if (age_n == LAT + 1) begin
            mode_n = 2; w_n = 0; sw_n = '0;
          end
        end
      end else begin
        if (!turn || game_result != 2'b00) mode_n = 0;
        else begin
          w_n = m_w + 1;
          if (w_n == ACK) mode_n = 0;
        end
      end
      m_mode <= mode_n; m_age <= age_n; m_w <= w_n; m_sw <= sw_n; m_btn <= btn_n; m_mv <= mv_n;
    end
  end

  always @(negedge clk) begin
    chk("sw_out", 32'(sw_out), 32'(m_sw));
    chk("btn_out", 32'(btn_out), 32'(m_btn));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("move_idx", 32'(move_idx), 32'(m_mv));
    chk("sw_onehot0", 32'($onehot0(sw_out)), 32'd1);
    chk("btn_single", 32'(btn_out && btn_prev), 32'd0);
    btn_prev <= btn_out;
    if (btn_out) btn_seen <= btn_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    turn = 1'b0; enable = 1'b1; game_result = 2'b00;
    repeat (n) step();
  endtask

  task automatic wait_pulse(input int budget, output int p);
    p = -1;
    for (int i = 0; i < budget && p < 0; i++) begin
      step();
      if (btn_out) p = cyc;
    end
  endtask

  task automatic directed(input string name, input logic [17:0] g, input int exp_mv);
    int e0, p;
    go_idle(3);
    grid_state = g;
    turn = 1'b1;
    e0 = cyc + 1;
    wait_pulse(LAT + 20, p);
    chk({name, "_latency"}, 32'(p - e0), 32'(LAT));
    chk({name, "_move"}, 32'(move_idx), 32'(exp_mv));
    chk({name, "_sw"}, 32'(sw_out), 32'(9'(1) << (exp_mv - 1)));
    step();
    turn = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e0, p1, p2, base, kind, sel, r;
    logic [17:0] g;
    #1;
    chk("rst_sw", 32'(sw_out), 32'd0);
    chk("rst_btn", 32'(btn_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_move", 32'(move_idx), 32'd0);
    #22 reset_flag = 1'b0;
    step();

    directed("win", board(9'b000011000, 9'b000000011), 3);
    directed("block", board(9'b000010001, 9'b000000010), 9);
    directed("open_x1", board(9'b000000001, 9'b0), 5);
    directed("open_x5", board(9'b000010000, 9'b0), 1);

    // Abort while thinking.
    go_idle(3);
    grid_state = board(9'b0, 9'b0);
    turn = 1'b1;
    repeat (5) step();
    game_result = 2'b01;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sw", 32'(sw_out), 32'd0);
    base = btn_seen;
    repeat (40) step();
    chk("abort_nopulse", 32'(btn_seen - base), 32'd0);

    // Asynchronous reset while driving the switch word.
    go_idle(3);
    grid_state = board(9'b000000001, 9'b0);
    turn = 1'b1;
    repeat (T + 11) step();
    chk("drive_sw", 32'(sw_out), 32'h010);
    #2 reset_flag = 1'b1;
    #1;
    chk("rst_drive_sw", 32'(sw_out), 32'd0);
    chk("rst_drive_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_flag = 1'b0;
    base = btn_seen;
    repeat (50) step();
    chk("rst_drive_nopulse", 32'(btn_seen - base), 32'd0);

    // No acknowledge: timeout then retry.
    go_idle(3);
    grid_state = board(9'b000000001, 9'b0);
    turn = 1'b1;
    wait_pulse(LAT + 20, p1);
    step();
    chk("noack_wait_sw", 32'(sw_out), 32'd0);
    chk("noack_wait_busy", 32'(busy), 32'd1);
    wait_pulse(ACK + LAT + 40, p2);
    chk("noack_gap", 32'(p2 - p1), 32'(ACK + T + H + 12));
    step();
    turn = 1'b0;
    step();

    // Full board: nothing to play.
    go_idle(3);
    grid_state = board(9'b101011010, 9'b010100101);
    turn = 1'b1;
    repeat (T + 11) step();
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_move", 32'(move_idx), 32'd0);
    chk("full_sw", 32'(sw_out), 32'd0);

    for (int s = 0; s < 40; s++) begin
      go_idle($urandom_range(2, 5));
      g = '0;
      for (int k = 0; k < 9; k++) begin
        r = $urandom_range(0, 5);
        g[2*k +: 2] = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r == 4) ? 2'b00 : 2'b11;
      end
      grid_state = g;
      turn = 1'b1;
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        repeat ($urandom_range(1, LAT + 2)) step();
        sel = $urandom_range(0, 2);
        if (sel == 0) enable = 1'b0;
        else if (sel == 1) turn = 1'b0;
        else game_result = 2'($urandom_range(1, 3));
      end else if (kind == 2) begin
        repeat (ACK + LAT + $urandom_range(0, 20)) step();
      end else begin
        repeat (LAT + 1 + $urandom_range(0, 6)) step();
        if ($urandom_range(0, 1) == 0) turn = 1'b0;
        else game_result = 2'($urandom_range(1, 3));
      end
      repeat (2) step();
    end

    go_idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
